node_driver: RTL and testbench

NODE_DRIVER -- requirements
Module: node_driver

---
 rtl/node_driver_if.sv | 42 ++++
 rtl/node_driver.sv | 167 ++++++++++++++++
 tb/tb_node_driver.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/node_driver_if.sv
// Signal bundle between node_driver, its upstream word source, the compute node
// and the downstream result consumer.
interface node_driver_if #(
    parameter int NUM_WORDS = 28
);
    logic                     s_valid;
    logic                     s_ready;
    logic [4:0]               s_data;
    logic                     s_last;

    logic [5*NUM_WORDS-1:0]   node_params;
    logic                     node_in_ready;
    logic [16:0]              node_out0;
    logic [16:0]              node_out1;
    logic                     node_out_ready;

    logic                     m_valid;
    logic                     m_ready;
    logic [33:0]              m_data;

    logic                     busy;
    logic                     err_frame;
    logic                     err_timeout;

    modport slave (
        input  s_valid, s_data, s_last,
        input  node_out0, node_out1, node_out_ready,
        input  m_ready,
        output s_ready, node_params, node_in_ready,
        output m_valid, m_data,
        output busy, err_frame, err_timeout
    );

    modport master (
        output s_valid, s_data, s_last,
        output node_out0, node_out1, node_out_ready,
        output m_ready,
        input  s_ready, node_params, node_in_ready,
        input  m_valid, m_data,
        input  busy, err_frame, err_timeout
    );
endinterface

// File: rtl/node_driver.sv
// Collects one frame of 5-bit words into a parameter register, fires the node,
// waits (bounded) for its result and hands the result downstream.
//
// state  | meaning
// LOAD   | accepting frame words into node_params
// FIRE   | one-cycle start pulse to the node
// WAIT   | waiting for node_out_ready, bounded by TIMEOUT
// RESULT | presenting m_data until downstream accepts
module node_driver #(
    parameter int NUM_WORDS = 28,
    parameter int TIMEOUT   = 15
) (
    input logic          clk,
    input logic          rst_n,
    node_driver_if.slave bus
);
    localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_WORDS - 1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        FIRE   = 2'd1,
        WAIT   = 2'd2,
        RESULT = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [IW-1:0]          idx;
    logic [IW-1:0]          idx_nxt;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_nxt;
    logic [5*NUM_WORDS-1:0] params_q;
    logic [33:0]            m_data_q;
    logic                   in_ready_q;
    logic                   m_valid_q;
    logic                   err_frame_q;
    logic                   err_timeout_q;

    logic                   accept;
    logic                   capture;
    logic                   in_ready_nxt;
    logic                   m_valid_nxt;
    logic                   err_frame_nxt;
    logic                   err_timeout_nxt;

    always_comb begin
        state_nxt       = state;
        idx_nxt         = idx;
        cnt_nxt         = cnt;
        accept          = 1'b0;
        capture         = 1'b0;
        in_ready_nxt    = 1'b0;
        m_valid_nxt     = 1'b0;
        err_frame_nxt   = 1'b0;
        err_timeout_nxt = 1'b0;

        case (state)
            LOAD: begin
                accept = bus.s_valid;
                if (accept) begin
                    if (idx == LAST_IDX) begin
                        idx_nxt = '0;
                        if (bus.s_last) begin
                            state_nxt    = FIRE;
                            in_ready_nxt = 1'b1;
                        end else begin
                            err_frame_nxt = 1'b1;
                        end
                    end else if (bus.s_last) begin
                        idx_nxt       = '0;
                        err_frame_nxt = 1'b1;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end

            FIRE: begin
                state_nxt = WAIT;
                cnt_nxt   = '0;
            end

            WAIT: begin
                if (bus.node_out_ready) begin
                    capture     = 1'b1;
                    m_valid_nxt = 1'b1;
                    state_nxt   = RESULT;
                end else if (cnt == CNT_LIMIT) begin
                    // TIMEOUT cycles spent in WAIT without a result
                    err_timeout_nxt = 1'b1;
                    cnt_nxt         = '0;
                    state_nxt       = LOAD;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            RESULT: begin
                if (bus.m_ready) begin
                    state_nxt = LOAD;
                end else begin
                    m_valid_nxt = 1'b1;
                end
            end

            default: begin
                state_nxt = LOAD;
                idx_nxt   = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= LOAD;
            idx           <= '0;
            cnt           <= '0;
            in_ready_q    <= 1'b0;
            m_valid_q     <= 1'b0;
            err_frame_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state         <= state_nxt;
            idx           <= idx_nxt;
            cnt           <= cnt_nxt;
            in_ready_q    <= in_ready_nxt;
            m_valid_q     <= m_valid_nxt;
            err_frame_q   <= err_frame_nxt;
            err_timeout_q <= err_timeout_nxt;
        end
    end

    // Parameter slots only move on accepted words, so they stay frozen while the node computes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            params_q <= '0;
        end else if (accept) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                if (idx == IW'(k)) begin
                    params_q[5*k +: 5] <= bus.s_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data_q <= '0;
        end else if (capture) begin
            m_data_q <= {bus.node_out1, bus.node_out0};
        end
    end

    assign bus.s_ready       = (state == LOAD);
    assign bus.busy          = (state != LOAD);
    assign bus.node_params   = params_q;
    assign bus.node_in_ready = in_ready_q;
    assign bus.m_valid       = m_valid_q;
    assign bus.m_data        = m_data_q;
    assign bus.err_frame     = err_frame_q;
    assign bus.err_timeout   = err_timeout_q;

endmodule

// File: tb/tb_node_driver.sv
// Directed bench for node_driver: expected results are queued at stimulus time
// and a monitor pops and compares on every downstream handshake.
module tb_node_driver;
    localparam int NW = 28;
    localparam int TO = 15;

    logic clk;
    logic rst_n;
    node_driver_if #(.NUM_WORDS(NW)) bus ();

    node_driver #(.NUM_WORDS(NW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          in_cnt = 0;
    int          ef_cnt = 0;
    int          to_cnt = 0;
    int          last_cyc = 0;
    int          stub_mode = 0;
    bit          stray_req = 0;
    logic [16:0] stub_out0 = '0;
    logic [16:0] stub_out1 = '0;
    logic [4:0]  frame_words [NW];
    logic [33:0] exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [139:0] act, input logic [139:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    function automatic logic [5*NW-1:0] param_model();
        logic [5*NW-1:0] v;
        v = '0;
        for (int k = 0; k < NW; k++) v[5*k +: 5] = frame_words[k];
        return v;
    endfunction

    // Scoreboard monitor plus pulse bookkeeping
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.node_in_ready) in_cnt++;
            if (bus.err_frame) ef_cnt++;
            if (bus.err_timeout) to_cnt++;
            if (bus.err_frame || bus.err_timeout)
                chk("err_exclusive", {bus.err_frame, bus.err_timeout} == 2'b11, 1'b0);
            if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("m_data unexpected_handshake");
                end else begin
                    chk("m_data scoreboard", bus.m_data, exp_q.pop_front());
                end
            end
        end
    end

    // Stub node: answers 3 cycles after the start pulse (mode 0) or never (mode 1)
    initial begin
        bus.node_out_ready = 1'b0;
        bus.node_out0 = '0;
        bus.node_out1 = '0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.node_in_ready && stub_mode == 0) begin
                repeat (3) @(posedge clk);
                #1;
                bus.node_out0 = stub_out0;
                bus.node_out1 = stub_out1;
                bus.node_out_ready = 1'b1;
                @(posedge clk);
                #1 bus.node_out_ready = 1'b0;
            end else if (stray_req) begin
                @(posedge clk);
                #1;
                bus.node_out0 = 17'h0AAAA;
                bus.node_out1 = 17'h15555;
                bus.node_out_ready = 1'b1;
                @(posedge clk);
                #1 bus.node_out_ready = 1'b0;
            end
        end
    end

    task automatic send_frame(input int n, input int last_idx);
        @(posedge clk);
        #1;
        for (int k = 0; k < n; k++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = frame_words[k];
            bus.s_last  = (k == last_idx);
            @(negedge clk);
            if (k == n - 1) last_cyc = cyc;
            @(posedge clk);
            #1;
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic wait_m_valid(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.m_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now(name);
    endtask

    task automatic run_normal(input string tag, input logic [33:0] exp);
        int n;
        int in_base;
        bit ok;
        stub_mode = 0;
        bus.m_ready = 1'b1;
        in_base = in_cnt;
        exp_q.push_back(exp);
        send_frame(NW, NW - 1);
        n = last_cyc;
        @(negedge clk);
        chk({tag, " in_ready"}, bus.node_in_ready, 1'b1);
        chk({tag, " in_ready_cycle"}, cyc - n, 1);
        wait_m_valid({tag, " m_valid_wait"}, ok);
        if (ok) begin
            chk({tag, " m_valid_latency"}, cyc - n, 5);
            chk({tag, " node_params"}, bus.node_params, param_model());
            @(negedge clk);
            chk({tag, " s_ready_return"}, bus.s_ready, 1'b1);
            chk({tag, " s_ready_cycle"}, cyc - n, 6);
        end
        chk({tag, " in_ready_pulses"}, in_cnt - in_base, 1);
    endtask

    initial begin
        int n;
        int base_ef;
        int base_in;
        int base_to;
        int fire_cyc;
        bit ok;
        logic [33:0] held;

        rst_n = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.s_last = 1'b0;
        bus.m_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", bus.busy, 1'b0);
        chk("rst m_valid", bus.m_valid, 1'b0);
        chk("rst m_data", bus.m_data, '0);
        chk("rst node_params", bus.node_params, '0);
        chk("rst outs", {bus.node_in_ready, bus.err_frame, bus.err_timeout}, 3'b000);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst s_ready", bus.s_ready, 1'b1);

        // Normal frame
        for (int k = 0; k < NW; k++) frame_words[k] = 5'(k % 16);
        stub_out0 = 17'h00010;
        stub_out1 = 17'h1FFFF;
        run_normal("normal", 34'h3FFFE0010);
        chk("normal slot5", bus.node_params[29:25], 5'd5);

        // Early last on word 10, then a good frame
        base_ef = ef_cnt;
        base_in = in_cnt;
        send_frame(11, 10);
        repeat (3) @(negedge clk);
        chk("early err_frame", ef_cnt - base_ef, 1);
        chk("early no_fire", in_cnt - base_in, 0);
        chk("early busy", bus.busy, 1'b0);
        for (int k = 0; k < NW; k++) frame_words[k] = 5'((7 * k + 3) % 32);
        stub_out0 = 17'h0ABCD;
        stub_out1 = 17'h10001;
        run_normal("after_early", {17'h10001, 17'h0ABCD});

        // Missing last
        base_ef = ef_cnt;
        base_in = in_cnt;
        send_frame(NW, -1);
        n = last_cyc;
        @(negedge clk);
        chk("missing err_frame_now", bus.err_frame, 1'b1);
        chk("missing err_cycle", cyc - n, 1);
        chk("missing busy", bus.busy, 1'b0);
        repeat (3) @(negedge clk);
        chk("missing no_fire", in_cnt - base_in, 0);
        chk("missing err_count", ef_cnt - base_ef, 1);

        // Timeout
        stub_mode = 1;
        held = bus.m_data;
        send_frame(NW, NW - 1);
        @(negedge clk);
        chk("timeout in_ready", bus.node_in_ready, 1'b1);
        fire_cyc = cyc;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.err_timeout) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            fail_now("timeout err_wait");
        end else begin
            chk("timeout cycle", cyc - (fire_cyc + 1), TO);
            chk("timeout s_ready", bus.s_ready, 1'b1);
            chk("timeout m_valid", bus.m_valid, 1'b0);
            chk("timeout m_data_held", bus.m_data, {17'h10001, 17'h0ABCD});
        end

        // Backpressure with stray node_out_ready pulses
        stub_mode = 0;
        bus.m_ready = 1'b0;
        for (int k = 0; k < NW; k++) frame_words[k] = 5'(31 - k);
        stub_out0 = 17'h12345;
        stub_out1 = 17'h00777;
        exp_q.push_back({17'h00777, 17'h12345});
        send_frame(NW, NW - 1);
        wait_m_valid("bp m_valid_wait", ok);
        for (int i = 0; i < 10; i++) begin
            if (i == 2 || i == 6) begin
                @(posedge clk);
                #1 stray_req = 1'b1;
                @(posedge clk);
                #1 stray_req = 1'b0;
            end
            @(negedge clk);
            chk("bp m_valid", bus.m_valid, 1'b1);
            chk("bp m_data", bus.m_data, {17'h00777, 17'h12345});
            chk("bp s_ready", bus.s_ready, 1'b0);
        end
        @(posedge clk);
        #1 bus.m_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp release s_ready", bus.s_ready, 1'b1);
        chk("bp release m_valid", bus.m_valid, 1'b0);

        // Reset while in WAIT
        stub_mode = 1;
        send_frame(NW, NW - 1);
        repeat (4) @(negedge clk);
        chk("rstwait busy_before", bus.busy, 1'b1);
        base_ef = ef_cnt;
        base_to = to_cnt;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rstwait busy", bus.busy, 1'b0);
        chk("rstwait params", bus.node_params, '0);
        chk("rstwait m_data", bus.m_data, '0);
        chk("rstwait outs", {bus.m_valid, bus.node_in_ready, bus.err_frame, bus.err_timeout}, 4'b0000);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (TO + 5) @(negedge clk);
        chk("rstwait no_err", (ef_cnt - base_ef) + (to_cnt - base_to), 0);
        for (int k = 0; k < NW; k++) frame_words[k] = 5'(k % 16);
        stub_out0 = 17'h00010;
        stub_out1 = 17'h1FFFF;
        run_normal("after_reset", 34'h3FFFE0010);

        repeat (3) @(negedge clk);
        chk("scoreboard drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
